// File: rtl/pipe_skid_if.sv
// Valid/ready bus between a pipeline stage and its neighbours; the stage takes the slave view.
// Both sides of the handshake are included so one interface instance covers a whole stage.
interface pipe_skid_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [CTRL_W-1:0] i_ctrl;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [CTRL_W-1:0] o_ctrl;

    modport master (
        output i_valid, i_data, i_ctrl, i_ready,
        input  o_ready, o_valid, o_data, o_ctrl
    );

    modport slave (
        input  i_valid, i_data, i_ctrl, i_ready,
        output o_ready, o_valid, o_data, o_ctrl
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register with 2-entry skid buffer, flush and bubble counter.
// Latency: 1 cycle from accept to o_valid/o_data.
// Backpressure: absorbs one entry after i_ready drops; o_ready is a flop, no i_ready->o_ready path.
module pipe_skid_stage #(
    parameter int DATA_W    = 128,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16,
    parameter bit KILL_CTRL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    pipe_skid_if.slave       bus,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    // Encoding chosen so bit 0 is the main valid bit and bit 1 the skid valid bit.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_dat_q;
    logic [DATA_W-1:0] skid_dat_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [CNT_W-1:0]  bubble_cnt_q;

    logic main_vld;
    logic skid_vld;
    logic accept;
    logic drain;
    logic main_ld_in;
    logic main_ld_skid;
    logic skid_ld;

    assign main_vld = state_q[0];
    assign skid_vld = state_q[1];
    assign accept   = bus.i_valid & ~skid_vld;
    assign drain    = main_vld & bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d    = S_ONE;
                    main_ld_in = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    main_ld_in = 1'b1;
                end else if (accept) begin
                    state_d = S_FULL;
                    skid_ld = 1'b1;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (drain) begin
                    state_d      = S_ONE;
                    main_ld_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush discards everything, including whatever is offered this cycle.
        if (i_flush) begin
            state_d      = S_EMPTY;
            main_ld_in   = 1'b0;
            main_ld_skid = 1'b0;
            skid_ld      = 1'b0;
        end
    end

    always_comb begin
        bus.o_valid = main_vld;
        bus.o_ready = ~skid_vld;
        bus.o_data  = main_dat_q;
        bus.o_ctrl  = KILL_CTRL ? (main_ctrl_q & {CTRL_W{main_vld}}) : main_ctrl_q;
    end

    // Payload registers hold through drain and flush; only loads or reset change them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            main_dat_q  <= '0;
            main_ctrl_q <= '0;
            skid_dat_q  <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (main_ld_in) begin
                main_dat_q  <= bus.i_data;
                main_ctrl_q <= bus.i_ctrl;
            end else if (main_ld_skid) begin
                main_dat_q  <= skid_dat_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (skid_ld) begin
                skid_dat_q  <= bus.i_data;
                skid_ctrl_q <= bus.i_ctrl;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bubble_cnt_q <= '0;
        end else if (!main_vld && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage with an in-order scoreboard of accepted entries.
module tb_pipe_skid_stage;

    typedef struct packed {
        logic [127:0] d;
        logic [7:0]   c;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [3:0] bubble_cnt;

    int   vectors = 0;
    int   errs    = 0;
    ent_t sb[$];

    pipe_skid_if #(.DATA_W(128), .CTRL_W(8)) bus ();

    pipe_skid_stage #(
        .DATA_W(128), .CTRL_W(8), .CNT_W(4), .KILL_CTRL(1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .bus         (bus),
        .o_bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        vectors++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic drive(input int v);
        bus.i_valid = 1'b1;
        bus.i_data  = 128'(v);
        bus.i_ctrl  = 8'(v);
    endtask

    // One clock: score drains/accepts on the falling edge, then advance past the rising edge.
    task automatic step();
        ent_t e;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.o_valid && bus.i_ready) begin
                chk("sb_nonempty_on_drain", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("drain_data", bus.o_data, e.d);
                    chk("drain_ctrl", 128'(bus.o_ctrl), 128'(e.c));
                end
            end
            if (flush) begin
                sb.delete();
            end else if (bus.i_valid && bus.o_ready) begin
                e.d = bus.i_data;
                e.c = bus.i_ctrl;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ctrl  = '0;
        bus.i_ready = 1'b0;
        step();
        step();
        chk("rst_o_valid", 128'(bus.o_valid), 128'(0));
        chk("rst_o_ready", 128'(bus.o_ready), 128'(1));
        chk("rst_o_data", bus.o_data, 128'(0));
        chk("rst_o_ctrl", 128'(bus.o_ctrl), 128'(0));
        chk("rst_bubble", 128'(bubble_cnt), 128'(0));

        // Full-rate stream 1..8 straight out of reset
        rst_n       = 1'b1;
        bus.i_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(i);
            step();
            chk("stream_o_ready", 128'(bus.o_ready), 128'(1));
            chk("stream_o_valid", 128'(bus.o_valid), 128'(1));
            chk("stream_o_data", bus.o_data, 128'(i));
        end
        chk("stream_bubble", 128'(bubble_cnt), 128'(1));
        bus.i_valid = 1'b0;
        step();
        chk("stream_idle_valid", 128'(bus.o_valid), 128'(0));

        // Back-pressure: i_ready low for three cycles once entry 2 is shown
        drive(1); step();
        chk("bp_data1", bus.o_data, 128'(1));
        drive(2); step();
        chk("bp_data2", bus.o_data, 128'(2));
        bus.i_ready = 1'b0;
        drive(3); step();
        chk("bp_skid_ready", 128'(bus.o_ready), 128'(0));
        chk("bp_hold_a", bus.o_data, 128'(2));
        drive(4); step();
        chk("bp_hold_b", bus.o_data, 128'(2));
        chk("bp_ready_b", 128'(bus.o_ready), 128'(0));
        step();
        chk("bp_hold_c", bus.o_data, 128'(2));
        bus.i_ready = 1'b1;
        step();
        chk("bp_release_ready", 128'(bus.o_ready), 128'(1));
        chk("bp_release_data", bus.o_data, 128'(3));
        step();
        chk("bp_data4", bus.o_data, 128'(4));
        drive(5); step();
        chk("bp_data5", bus.o_data, 128'(5));
        drive(6); step();
        chk("bp_data6", bus.o_data, 128'(6));
        bus.i_valid = 1'b0;
        step();
        chk("bp_sb_empty", 128'(sb.size()), 128'(0));

        // Flush while FULL with 5 in main and 6 in skid, 7 offered
        bus.i_ready = 1'b0;
        drive(5); step();
        drive(6); step();
        chk("fl_full_ready", 128'(bus.o_ready), 128'(0));
        chk("fl_full_data", bus.o_data, 128'(5));
        flush = 1'b1;
        drive(7); step();
        flush       = 1'b0;
        bus.i_valid = 1'b0;
        chk("fl_o_valid", 128'(bus.o_valid), 128'(0));
        chk("fl_o_ctrl", 128'(bus.o_ctrl), 128'(0));
        chk("fl_o_ready", 128'(bus.o_ready), 128'(1));
        chk("fl_data_held", bus.o_data, 128'(5));
        chk("fl_sb_empty", 128'(sb.size()), 128'(0));
        bus.i_ready = 1'b1;
        step();
        chk("fl_still_empty", 128'(bus.o_valid), 128'(0));
        drive(9); step();
        chk("fl_after_data", bus.o_data, 128'(9));
        bus.i_valid = 1'b0;
        step();

        // Control kill on alternating valid slots
        for (int k = 0; k < 6; k++) begin
            drive(k + 16);
            bus.i_ctrl  = 8'hFF;
            bus.i_valid = ((k % 2) == 0);
            step();
            chk("kill_valid", 128'(bus.o_valid), 128'((k % 2) == 0));
            chk("kill_ctrl", 128'(bus.o_ctrl), ((k % 2) == 0) ? 128'(8'hFF) : 128'(0));
        end

        // Bubble counter saturation and clear by reset
        bus.i_valid = 1'b0;
        rst_n       = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("sat_bubble", 128'(bubble_cnt), 128'((i < 15) ? i : 15));
        end
        rst_n = 1'b0;
        step();
        chk("sat_rst_bubble", 128'(bubble_cnt), 128'(0));
        chk("sat_rst_valid", 128'(bus.o_valid), 128'(0));
        rst_n = 1'b1;

        // Reset and flush together from FULL
        bus.i_ready = 1'b0;
        drive(171); step();
        drive(205); step();
        chk("rf_pre_data", bus.o_data, 128'(171));
        flush = 1'b1;
        rst_n = 1'b0;
        step();
        chk("rf_o_valid", 128'(bus.o_valid), 128'(0));
        chk("rf_o_ready", 128'(bus.o_ready), 128'(1));
        chk("rf_o_data", bus.o_data, 128'(0));
        chk("rf_o_ctrl", 128'(bus.o_ctrl), 128'(0));
        chk("rf_bubble", 128'(bubble_cnt), 128'(0));
        flush       = 1'b0;
        rst_n       = 1'b1;
        bus.i_valid = 1'b0;
        step();
        chk("rf_idle_valid", 128'(bus.o_valid), 128'(0));
        bus.i_ready = 1'b1;
        drive(85); step();
        chk("rf_after_data", bus.o_data, 128'(85));
        bus.i_valid = 1'b0;
        step();
        chk("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline stage register that generalises the fixed inter-stage registers (IF/ID … MEM/WB). Carries a DATA_W-bit data payload and a CTRL_W-bit control bundle with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and synchronous flush. Control bits are killed on invalid slots, and a saturating counter tracks bubble cycles. Sits between any two pipeline stages. It also replaces the stall/flush "sel" style of the existing stage registers.

## Interface
- DATA_W, 128: payload width (e.g. instr, pc+4, alu, load data concatenated)
- CTRL_W, 8: control bundle width (e.g. rd_addr, rd_wren, wb_sel)
- CNT_W, 16: bubble counter width
- KILL_CTRL, 1: 1 = o_ctrl forced to 0 whenever o_valid=0

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_flush  in  1  synchronous flush of all held entries
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept an entry this cycle
- i_data  in  DATA_W  upstream payload
- i_ctrl  in  CTRL_W  upstream control
- o_valid  out  1  downstream entry valid
- i_ready  in  1  downstream accepts this cycle
- o_data  out  DATA_W  payload to downstream
- o_ctrl  out  CTRL_W  control to downstream
- o_bubble_cnt  out  CNT_W  saturating count of cycles with o_valid=0

## Operation
- accept = i_valid & o_ready; drain = o_valid & i_ready.
- Storage: main register (drives outputs) and skid register, each with a valid bit. State = EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
- o_valid = main valid. o_ready = !skid valid. Both outputs come straight from flops; no combinational path from i_ready to o_ready.
- EMPTY:
  - accept → ONE, main ← input.
- ONE:
  - accept & drain → ONE, main ← input.
  - accept & !drain → FULL, skid ← input.
  - !accept & drain → EMPTY.
  - else hold.
- FULL (o_ready=0):
  - drain → ONE, main ← skid.
  - else hold.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush has priority over every transition: next state EMPTY. Any input offered in the flush cycle is discarded, even if i_valid=1. A drain in the flush cycle still counts as consumed by downstream.
- Reset has priority over flush. In reset: state EMPTY, main/skid data and ctrl ← 0, o_bubble_cnt ← 0.
- Data registers load only on accept or skid→main move. Otherwise they hold and are not cleared on drain or flush.
- KILL_CTRL=1: o_ctrl = main ctrl & {CTRL_W{o_valid}}, so a bubble never writes the regfile.
- o_bubble_cnt increments by 1 each non-reset cycle where o_valid=0 and saturates at 2^CNT_W−1. Flush does not clear it.

## Timing
- Reset values: o_valid=0, o_ready=1, o_data=0, o_ctrl=0, o_bubble_cnt=0.
- o_ready reads 1 in the first cycle after reset release.
- Latency: an entry accepted at edge N is on o_data/o_valid after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle sustained while i_ready=1.
- Back-pressure: after i_ready drops, the stage absorbs one more entry, then o_ready=0 from the next cycle.
- Release: o_ready returns to 1 in the cycle after the first drain from FULL.
- Simultaneous accept+drain in ONE: main is replaced in place and the state stays ONE.
- Flush in FULL: both entries are gone after the edge, and o_ready=1, o_valid=0 in the next cycle.
- Reset mid-operation: all held entries are lost; behaviour is identical to power-up reset.

## Test plan
- Reset, then stream i_data=1..8 with i_valid=1, i_ready=1 → o_data=1..8 on consecutive cycles, 1-cycle latency, o_ready constant 1, o_bubble_cnt=1 (first cycle only).
- Stream 1..6 with i_ready=0 for 3 cycles after entry 2 is shown → o_ready=0 after entry 3 is skidded; output sequence 1..6 with no loss or duplicate, o_data held at 2 during the stall.
- FULL with entries 5 (main) and 6 (skid), assert i_flush with i_valid=1, i_data=7 → next cycle o_valid=0, o_ctrl=0, o_ready=1; 5, 6 and 7 never appear at the output.
- KILL_CTRL=1, i_ctrl=8'hFF, i_valid toggling 1/0 → o_ctrl alternates 8'hFF/8'h00, aligned with o_valid.
- CNT_W=4, idle 20 cycles after reset → o_bubble_cnt reaches 15 and stays there; assert i_rst_n=0 for 1 cycle → o_bubble_cnt=0, o_valid=0.
- Drive i_flush and i_rst_n=0 in the same cycle → reset values result and the data registers read 0.
